microcode_sequencer: RTL and testbench

//   Step sequencer for the microcoded control unit. Keeps the microstep counter and the

---
 rtl/microcode_sequencer.sv | 113 +++++++++++
 tb/tb_microcode_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microstep sequencer: step counter, extended page bit, ROM address, RUN/BRK/HALT.
// Optional SEQ_WATCHDOG_EN traps a step overflow into HALT with fault set.
module microcode_sequencer #(
    parameter int STEP_W   = 3,
    parameter int OPCODE_W = 8,
    parameter int FLAGS_W  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [OPCODE_W-1:0]                 opcode,
    input  logic [FLAGS_W-1:0]                  flags,
    input  logic [31:0]                         control_word,
    input  logic                                resume,
    output logic [FLAGS_W+1+OPCODE_W+STEP_W-1:0] rom_addr,
    output logic [STEP_W-1:0]                   step,
    output logic                                ext_page,
    output logic                                clk_en,
    output logic                                halted,
    output logic                                in_break,
    output logic                                fault
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_BRK  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ext_q, ext_d;
    logic              fault_q, fault_d;

    logic cw_step_reset;
    logic cw_step_ext;
    logic cw_halt;
    logic cw_brk;

    assign cw_step_reset = control_word[24];
    assign cw_step_ext   = control_word[25];
    assign cw_halt       = control_word[26];
    assign cw_brk        = control_word[27];

    // Sequencing registers; only rst reaches them while outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            step_q  <= '0;
            ext_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ext_q   <= ext_d;
            fault_q <= fault_d;
        end
    end

    // Next step/page/state from the current control word and run state.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ext_d   = ext_q;
        fault_d = fault_q;
        unique case (state_q)
            S_RUN: begin
                if (cw_step_reset) begin
                    step_d = '0;
                    ext_d  = 1'b0;
                end else if (cw_step_ext) begin
                    step_d = '0;
                    ext_d  = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                end else if (step_q == STEP_MAX) begin
                    fault_d = 1'b1;
`endif
                end else begin
                    step_d = step_q + 1'b1;
                end
                if (fault_d || cw_halt) begin
                    state_d = S_HALT;
                end else if (cw_brk) begin
                    state_d = S_BRK;
                end
            end
            S_BRK: begin
                if (resume) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
`ifndef SEQ_WATCHDOG_EN
        fault_d = 1'b0;
`endif
    end

    assign rom_addr = {flags, ext_q, opcode, step_q};
    assign step     = step_q;
    assign ext_page = ext_q;
    assign clk_en   = (state_q == S_RUN);
    assign halted   = (state_q == S_HALT);
    assign in_break = (state_q == S_BRK);
    assign fault    = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer.
// Expectations follow SEQ_WATCHDOG_EN when it is defined for the build.
module tb_microcode_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  opcode;
    logic [3:0]  flags;
    logic [31:0] control_word;
    logic        resume;
    logic [15:0] rom_addr;
    logic [2:0]  step;
    logic        ext_page;
    logic        clk_en;
    logic        halted;
    logic        in_break;
    logic        fault;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] B24 = 32'h0100_0000;
    localparam logic [31:0] B25 = 32'h0200_0000;
    localparam logic [31:0] B26 = 32'h0400_0000;
    localparam logic [31:0] B27 = 32'h0800_0000;

    microcode_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .flags        (flags),
        .control_word (control_word),
        .resume       (resume),
        .rom_addr     (rom_addr),
        .step         (step),
        .ext_page     (ext_page),
        .clk_en       (clk_en),
        .halted       (halted),
        .in_break     (in_break),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag, input logic [2:0] s,
                           input logic e);
        chk({tag, ".step"}, 32'(step), 32'(s));
        chk({tag, ".ext"}, 32'(ext_page), 32'(e));
        chk({tag, ".clk_en"}, 32'(clk_en), 32'd1);
        chk({tag, ".brk"}, 32'(in_break), 32'd0);
        chk({tag, ".halt"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        opcode = 8'h12;
        flags = 4'h0;
        control_word = 32'h0;
        resume = 1'b0;
        #2;
        tick();
        chk_run("reset", 3'd0, 1'b0);
        chk("reset.fault", 32'(fault), 32'd0);
        chk("reset.addr", 32'(rom_addr), 32'h0090);

        rst = 1'b0;
        control_word = 32'h00FF_FFFF;
        tick();
        chk_run("inc1", 3'd1, 1'b0);
        control_word = 32'hF000_0000;
        tick();
        chk_run("inc2", 3'd2, 1'b0);
        control_word = 32'h0;
        tick();
        chk_run("inc3", 3'd3, 1'b0);
        chk("inc3.addr", 32'(rom_addr), 32'h0093);

        rst = 1'b1;
        control_word = B26 | B27;
        tick();
        chk_run("rst2", 3'd0, 1'b0);
        rst = 1'b0;
        control_word = 32'h0;
        tick();
        tick();
        chk_run("at2", 3'd2, 1'b0);
        control_word = B24 | B25;
        tick();
        chk_run("rstwins", 3'd0, 1'b0);
        control_word = B25;
        tick();
        chk_run("ext", 3'd0, 1'b1);
        tick();
        chk_run("extstay", 3'd0, 1'b1);
        opcode = 8'h34;
        flags = 4'hA;
        #1;
        chk("addr.live", 32'(rom_addr), 32'hA9A0);
        control_word = 32'h0;
        tick();
        chk_run("extinc", 3'd1, 1'b1);
        control_word = B24;
        tick();
        chk_run("extclr", 3'd0, 1'b0);
        opcode = 8'h12;
        flags = 4'h0;

        control_word = 32'h0;
        repeat (4) tick();
        chk_run("at4", 3'd4, 1'b0);
        control_word = B27;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("brk.in", 32'(in_break), 32'd1);
        chk("brk.clk_en", 32'(clk_en), 32'd0);
        chk("brk.step", 32'(step), 32'd5);
        control_word = B24;
        tick();
        control_word = B26;
        tick();
        control_word = B25 | B27;
        tick();
        chk("brkhold.step", 32'(step), 32'd5);
        chk("brkhold.ext", 32'(ext_page), 32'd0);
        chk("brkhold.in", 32'(in_break), 32'd1);
        chk("brkhold.halt", 32'(halted), 32'd0);
        flags = 4'h3;
        #1;
        chk("brk.addr", 32'(rom_addr), 32'h3095);
        flags = 4'h0;
        control_word = B24;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        control_word = 32'h0;
        chk_run("resume", 3'd5, 1'b0);
        tick();
        chk_run("resume2", 3'd6, 1'b0);

        control_word = B26 | B27;
        tick();
        chk("halt.h", 32'(halted), 32'd1);
        chk("halt.b", 32'(in_break), 32'd0);
        chk("halt.clk_en", 32'(clk_en), 32'd0);
        chk("halt.step", 32'(step), 32'd7);
        control_word = 32'h0;
        resume = 1'b1;
        tick();
        tick();
        resume = 1'b0;
        tick();
        chk("halt.stay", 32'(halted), 32'd1);
        chk("halt.step2", 32'(step), 32'd7);
        chk("halt.fault", 32'(fault), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_run("halt.rst", 3'd0, 1'b0);

        repeat (7) tick();
        chk_run("at7", 3'd7, 1'b0);
        tick();
`ifdef SEQ_WATCHDOG_EN
        chk("wd.fault", 32'(fault), 32'd1);
        chk("wd.halt", 32'(halted), 32'd1);
        chk("wd.step", 32'(step), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wd.clr", 32'(fault), 32'd0);
        chk_run("wd.rst", 3'd0, 1'b0);
`else
        chk_run("wrap", 3'd0, 1'b0);
        chk("wrap.fault", 32'(fault), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
